mem_except_unit: RTL and testbench

//  Exception/ERET decision logic at the MEM stage; the producer side of the CP0 exception interface.
//  - Collects exception flags from the instruction in MEM and samples pending interrupts from CP0 Status/Cause.
//  - Drives a one-cycle exception record (excepttype/pc/bad_vaddr/delayslot) into the CP0 register file.
//  - Issues a pipeline flush with the redirect PC: the exception vector, or EPC for ERET.

---
 rtl/mem_except_if.sv | 46 ++++
 rtl/mem_except_unit.sv | 132 +++++++++++++
 tb/tb_mem_except_unit.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_except_if.sv
// CP0 exception interface between the MEM-stage exception unit and the pipeline/CP0.
// Optional macro TIMER_INT_EN adds the timer_int_i interrupt source.
interface mem_except_if;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned STALLW = 6;
  localparam int unsigned FLAGW  = 9;

  logic [STALLW-1:0] stall_i;
  logic              mem_valid_i;
  logic [XLEN-1:0]   mem_pc_i;
  logic              mem_dslot_i;
  logic [FLAGW-1:0]  mem_flags_i;
  logic [XLEN-1:0]   mem_addr_i;
  logic [XLEN-1:0]   status_i;
  logic [XLEN-1:0]   cause_i;
  logic [XLEN-1:0]   epc_i;
`ifdef TIMER_INT_EN
  logic              timer_int_i;
`endif
  logic [XLEN-1:0]   excepttype_o;
  logic [XLEN-1:0]   exc_pc_o;
  logic [XLEN-1:0]   bad_vaddr_o;
  logic              dslot_o;
  logic              flush_o;
  logic [XLEN-1:0]   new_pc_o;

  // Exception unit side: produces the record and the flush.
  modport master (
    output excepttype_o, exc_pc_o, bad_vaddr_o, dslot_o, flush_o, new_pc_o,
    input  stall_i, mem_valid_i, mem_pc_i, mem_dslot_i, mem_flags_i,
    input  mem_addr_i, status_i, cause_i, epc_i
`ifdef TIMER_INT_EN
   ,input  timer_int_i
`endif
  );

  // Pipeline/CP0 side: supplies MEM state and consumes the record.
  modport slave (
    input  excepttype_o, exc_pc_o, bad_vaddr_o, dslot_o, flush_o, new_pc_o,
    output stall_i, mem_valid_i, mem_pc_i, mem_dslot_i, mem_flags_i,
    output mem_addr_i, status_i, cause_i, epc_i
`ifdef TIMER_INT_EN
   ,output timer_int_i
`endif
  );
endinterface

// File: rtl/mem_except_unit.sv
// MEM-stage exception/ERET decision: prioritises exceptions and interrupts,
// emits a one-cycle CP0 record with a flush/redirect, then drains the pipeline.
// Optional macro TIMER_INT_EN: timer_int_i is ORed into IP7 before masking.
module mem_except_unit #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input logic          clk,
  input logic          rst_n,
  mem_except_if.master bus
);
  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;

  // mem_flags_i bit positions
  localparam int unsigned F_ADEL_IF = 0;
  localparam int unsigned F_ADEL_LD = 1;
  localparam int unsigned F_ADES    = 2;
  localparam int unsigned F_INVALID = 3;
  localparam int unsigned F_SYSCALL = 4;
  localparam int unsigned F_BRK     = 5;
  localparam int unsigned F_OV      = 6;
  localparam int unsigned F_TRAP    = 7;
  localparam int unsigned F_ERET    = 8;

  localparam logic [XLEN-1:0] CODE_INT  = 32'h01;
  localparam logic [XLEN-1:0] CODE_ADEL = 32'h04;
  localparam logic [XLEN-1:0] CODE_ADES = 32'h05;
  localparam logic [XLEN-1:0] CODE_SYS  = 32'h08;
  localparam logic [XLEN-1:0] CODE_BP   = 32'h09;
  localparam logic [XLEN-1:0] CODE_RI   = 32'h0a;
  localparam logic [XLEN-1:0] CODE_OV   = 32'h0c;
  localparam logic [XLEN-1:0] CODE_TR   = 32'h0d;
  localparam logic [XLEN-1:0] CODE_ERET = 32'h0e;

  typedef enum logic [1:0] {IDLE, FLUSH, DRAIN} state_t;

  state_t           state;
  logic [CNT_W-1:0] drain_cnt;

  logic [7:0]       ip_c;
  logic             int_p_c;
  logic             commit_c;
  logic [XLEN-1:0]  code_c;
  logic [XLEN-1:0]  bad_c;
  logic             unused_bits;

  // Status/Cause/stall bits this stage does not look at.
  assign unused_bits = ^{bus.status_i[31:16], bus.status_i[7:2],
                         bus.cause_i[31:16], bus.cause_i[7:0],
                         bus.stall_i[5], bus.stall_i[3:0]};

  // Interrupt qualification, commit condition and priority encoding.
  always_comb begin
    ip_c     = bus.cause_i[15:8];
`ifdef TIMER_INT_EN
    ip_c[7]  = ip_c[7] | bus.timer_int_i;
`endif
    int_p_c  = bus.status_i[0] & ~bus.status_i[1] & (|(ip_c & bus.status_i[15:8]));
    commit_c = (state == IDLE) & bus.mem_valid_i & ~bus.stall_i[4]
             & (int_p_c | (|bus.mem_flags_i));
    code_c   = '0;
    bad_c    = '0;
    if (int_p_c) begin
      code_c = CODE_INT;
    end else if (bus.mem_flags_i[F_ADEL_IF]) begin
      code_c = CODE_ADEL;
      bad_c  = bus.mem_pc_i;
    end else if (bus.mem_flags_i[F_INVALID]) begin
      code_c = CODE_RI;
    end else if (bus.mem_flags_i[F_SYSCALL]) begin
      code_c = CODE_SYS;
    end else if (bus.mem_flags_i[F_BRK]) begin
      code_c = CODE_BP;
    end else if (bus.mem_flags_i[F_TRAP]) begin
      code_c = CODE_TR;
    end else if (bus.mem_flags_i[F_OV]) begin
      code_c = CODE_OV;
    end else if (bus.mem_flags_i[F_ADEL_LD]) begin
      code_c = CODE_ADEL;
      bad_c  = bus.mem_addr_i;
    end else if (bus.mem_flags_i[F_ADES]) begin
      code_c = CODE_ADES;
      bad_c  = bus.mem_addr_i;
    end else if (bus.mem_flags_i[F_ERET]) begin
      code_c = CODE_ERET;
    end
  end

  // FSM and registered record: outputs pulse for the single FLUSH cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      drain_cnt        <= '0;
      bus.excepttype_o <= '0;
      bus.exc_pc_o     <= '0;
      bus.bad_vaddr_o  <= '0;
      bus.dslot_o      <= 1'b0;
      bus.flush_o      <= 1'b0;
      bus.new_pc_o     <= '0;
    end else begin
      bus.excepttype_o <= '0;
      bus.exc_pc_o     <= '0;
      bus.bad_vaddr_o  <= '0;
      bus.dslot_o      <= 1'b0;
      bus.flush_o      <= 1'b0;
      bus.new_pc_o     <= '0;
      case (state)
        IDLE: begin
          if (commit_c) begin
            state            <= FLUSH;
            bus.excepttype_o <= code_c;
            bus.exc_pc_o     <= bus.mem_pc_i;
            bus.bad_vaddr_o  <= bad_c;
            bus.dslot_o      <= bus.mem_dslot_i;
            bus.flush_o      <= 1'b1;
            bus.new_pc_o     <= (code_c == CODE_ERET) ? bus.epc_i : EXC_VECTOR;
          end
        end
        FLUSH: begin
          state     <= DRAIN;
          drain_cnt <= CNT_W'(DRAIN_CYCLES - 1);
        end
        DRAIN: begin
          if (drain_cnt == '0) state <= IDLE;
          else                 drain_cnt <= drain_cnt - CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_except_unit.sv
// Self-checking bench for mem_except_unit: directed cases plus randomized traffic
// against a cycle-count reference model of the exception rules.
module tb_mem_except_unit;
  localparam logic [31:0] VEC   = 32'hBFC00380;
  localparam int          DRAIN = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_except_if bus();

  mem_except_unit #(.EXC_VECTOR(VEC), .DRAIN_CYCLES(DRAIN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: cycles during which commits are still blocked.
  int          busy = 0;
  logic [31:0] exp_code, exp_pc, exp_bad, exp_newpc;
  logic        exp_dslot, exp_flush;

  // Priority order after interrupt: flag bit index and exception code.
  int          prio_bit  [9] = '{0, 3, 4, 5, 7, 6, 1, 2, 8};
  logic [31:0] prio_code [9] = '{32'h04, 32'h0a, 32'h08, 32'h09, 32'h0d,
                                 32'h0c, 32'h04, 32'h05, 32'h0e};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    busy = 0;
    exp_code = '0; exp_pc = '0; exp_bad = '0; exp_newpc = '0;
    exp_dslot = 1'b0; exp_flush = 1'b0;
  endfunction

  // Predicts outputs after the coming clock edge from the inputs presented now.
  function automatic void model_edge();
    logic [7:0] ip;
    logic       int_p;
    ip = bus.cause_i[15:8];
`ifdef TIMER_INT_EN
    if (bus.timer_int_i) ip[7] = 1'b1;
`endif
    int_p = bus.status_i[0] && !bus.status_i[1] && ((ip & bus.status_i[15:8]) != 8'h00);
    exp_code = '0; exp_pc = '0; exp_bad = '0; exp_newpc = '0;
    exp_dslot = 1'b0; exp_flush = 1'b0;
    if (busy == 0 && bus.mem_valid_i && !bus.stall_i[4] && (int_p || bus.mem_flags_i != 9'h0)) begin
      exp_flush = 1'b1;
      exp_pc    = bus.mem_pc_i;
      exp_dslot = bus.mem_dslot_i;
      if (int_p) begin
        exp_code = 32'h01;
      end else begin
        for (int i = 0; i < 9; i++) begin
          if (bus.mem_flags_i[prio_bit[i]]) begin
            exp_code = prio_code[i];
            if (prio_bit[i] == 0)                        exp_bad = bus.mem_pc_i;
            else if (prio_bit[i] == 1 || prio_bit[i] == 2) exp_bad = bus.mem_addr_i;
            break;
          end
        end
      end
      exp_newpc = (exp_code == 32'h0e) ? bus.epc_i : VEC;
      busy = 1 + DRAIN;
    end else if (busy > 0) begin
      busy--;
    end
  endfunction

  task automatic check_outputs(input string tag);
    check($sformatf("%s.code", tag),  bus.excepttype_o, exp_code);
    check($sformatf("%s.pc", tag),    bus.exc_pc_o,     exp_pc);
    check($sformatf("%s.bad", tag),   bus.bad_vaddr_o,  exp_bad);
    check($sformatf("%s.dslot", tag), 32'(bus.dslot_o), 32'(exp_dslot));
    check($sformatf("%s.flush", tag), 32'(bus.flush_o), 32'(exp_flush));
    check($sformatf("%s.newpc", tag), bus.new_pc_o,     exp_newpc);
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic set_in(input logic v, input logic [31:0] pc, input logic ds,
                        input logic [8:0] fl, input logic [31:0] addr,
                        input logic [31:0] st, input logic [31:0] ca,
                        input logic [31:0] epc, input logic [5:0] stall);
    bus.mem_valid_i = v;
    bus.mem_pc_i    = pc;
    bus.mem_dslot_i = ds;
    bus.mem_flags_i = fl;
    bus.mem_addr_i  = addr;
    bus.status_i    = st;
    bus.cause_i     = ca;
    bus.epc_i       = epc;
    bus.stall_i     = stall;
  endtask

  task automatic idle_in();
    set_in(1'b0, '0, 1'b0, 9'h0, '0, '0, '0, '0, 6'h0);
  endtask

  // Let a pending flush/drain run out with a quiet MEM stage.
  task automatic settle(input string tag);
    idle_in();
    for (int i = 0; i < 1 + DRAIN; i++) step(tag);
  endtask

  initial begin
`ifdef TIMER_INT_EN
    bus.timer_int_i = 1'b0;
`endif
    idle_in();
    rst_n = 1'b0;
    model_reset();
    #12;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Syscall, then held through FLUSH/DRAIN: blocked until the drain ends.
    set_in(1'b1, 32'h8000_1000, 1'b0, 9'h010, '0, '0, '0, '0, 6'h0);
    step("sys");
    check("sys_code_const", bus.excepttype_o, 32'h08);
    check("sys_newpc_const", bus.new_pc_o, VEC);
    for (int i = 0; i < 1 + DRAIN; i++) begin
      step("sys_drain");
      check("sys_drain_flush0", 32'(bus.flush_o), 32'h0);
    end
    step("sys_again");
    check("sys_again_flush1", 32'(bus.flush_o), 32'h1);
    settle("sys_settle");

    // Data-load address error in a delay slot.
    set_in(1'b1, 32'h8000_1100, 1'b1, 9'h002, 32'h0000_0003, '0, '0, '0, 6'h0);
    step("adel_ld");
    check("adel_ld_bad_const", bus.bad_vaddr_o, 32'h3);
    check("adel_ld_dslot_const", 32'(bus.dslot_o), 32'h1);
    settle("adel_settle");

    // Interrupt beats overflow.
    set_in(1'b1, 32'h8000_1200, 1'b0, 9'h040, '0, 32'h0000_0401, 32'h0000_0400, '0, 6'h0);
    step("int_ov");
    check("int_ov_code_const", bus.excepttype_o, 32'h01);
    settle("int_settle");

    // EXL masks a pending interrupt.
    set_in(1'b1, 32'h8000_1300, 1'b0, 9'h000, '0, 32'h0000_0403, 32'h0000_0400, '0, 6'h0);
    step("exl");
    check("exl_flush_const", 32'(bus.flush_o), 32'h0);

    // ERET redirects to EPC.
    set_in(1'b1, 32'h8000_1400, 1'b0, 9'h100, '0, 32'h0000_0002, '0, 32'h8000_2000, 6'h0);
    step("eret");
    check("eret_code_const", bus.excepttype_o, 32'h0e);
    check("eret_newpc_const", bus.new_pc_o, 32'h8000_2000);
    settle("eret_settle");

    // Syscall held under a MEM stall, then released.
    set_in(1'b1, 32'h8000_1500, 1'b0, 9'h010, '0, '0, '0, '0, 6'h10);
    for (int i = 0; i < 3; i++) step("stall");
    bus.stall_i = 6'h00;
    step("stall_rel");
    check("stall_rel_flush_const", 32'(bus.flush_o), 32'h1);
    settle("stall_settle");

    // Asynchronous reset in the middle of FLUSH.
    set_in(1'b1, 32'h8000_1600, 1'b0, 9'h010, '0, '0, '0, '0, 6'h0);
    step("pre_rst");
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_mid_flush", 32'(bus.flush_o), 32'h0);
    check("rst_mid_code", bus.excepttype_o, 32'h0);
    #2;
    rst_n = 1'b1;
    step("post_rst");
    check("post_rst_flush_const", 32'(bus.flush_o), 32'h1);
    step("post_rst_drain");
    check("post_rst_drain_const", 32'(bus.flush_o), 32'h0);
    settle("post_rst_settle");

`ifdef TIMER_INT_EN
    set_in(1'b1, 32'h8000_1700, 1'b0, 9'h000, '0, 32'h0000_8001, '0, '0, 6'h0);
    bus.timer_int_i = 1'b1;
    step("timer");
    check("timer_code_const", bus.excepttype_o, 32'h01);
    bus.timer_int_i = 1'b0;
    settle("timer_settle");
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 500; n++) begin
      logic [8:0]  fl;
      logic [31:0] st;
      int          r;
      r = $urandom_range(0, 9);
      if (r < 4)      fl = 9'h0;
      else if (r < 8) fl = 9'(1 << $urandom_range(0, 8));
      else            fl = 9'($urandom);
      st = $urandom;
      st[0] = ($urandom_range(0, 1) == 1);
      st[1] = ($urandom_range(0, 3) == 0);
      set_in($urandom_range(0, 3) != 0, $urandom, 1'($urandom), fl, $urandom,
             st, $urandom, $urandom, 6'($urandom) & ~6'h10);
      if ($urandom_range(0, 3) == 0) bus.stall_i[4] = 1'b1;
`ifdef TIMER_INT_EN
      bus.timer_int_i = ($urandom_range(0, 9) == 0);
`endif
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
